polytomsg_masked_decode_sched: RTL and testbench

- Sequencer for the masked Poly-to-message decode transform (Pow2 transform with an A2B stage and a 6-stage valid shift).
- Streams all KYBER_N share pairs (c1, c2) from the two share RAMs into the transform, paced by PRNG availability.
- Collects the returned (y1, y2) share pairs via the transform's data_valid and writes them, in order, to the result RAMs.
- Sits between the Kyber decryption top-level control (start/done) and the masked decode datapath.

---
 rtl/kyber_pkg.sv | 18 +
 rtl/polytomsg_sched_issue_ctr.sv | 55 +++++
 rtl/polytomsg_masked_decode_sched.sv | 150 +++++++++++++++
 tb/tb_polytomsg_masked_decode_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the decode-sequencer state encoding.
package kyber_pkg;

    localparam int KYBER_N  = 256;
    localparam int KYBER_Q  = 3329;
    localparam int COEFF_SZ = 16;
    localparam int RAND_SZ  = COEFF_SZ * 5;
    localparam int ADDR_SZ  = 8;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/polytomsg_sched_issue_ctr.sv
// Issue counter for the masked decode sequencer: walks the share RAM
// addresses, paces issues ISSUE_GAP cycles apart and consumes one PRNG
// word per issue, holding that word for the transform.
module polytomsg_sched_issue_ctr
    import kyber_pkg::*;
#(
    parameter int ISSUE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               prng_valid,
    input  logic [RAND_SZ-1:0] prng_data,
    output logic               issue,
    output logic [ADDR_SZ-1:0] addr,
    output logic               all_issued,
    output logic [RAND_SZ-1:0] prng_lat
);

    localparam int GW = $clog2(ISSUE_GAP) + 1;
    localparam logic [ADDR_SZ:0] N_CNT = (ADDR_SZ+1)'(KYBER_N);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);

    logic [ADDR_SZ:0] issue_cnt;
    logic [GW-1:0]    gap_cnt;

    // Reset is folded in so the RAM/PRNG strobes drop in the reset cycle itself.
    assign issue      = en && !rst && prng_valid && (gap_cnt == '0) && (issue_cnt < N_CNT);
    assign addr       = issue_cnt[ADDR_SZ-1:0];
    assign all_issued = (issue_cnt == N_CNT);

    // Issue count and gap pacing; a PRNG stall simply holds both.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            issue_cnt <= '0;
            gap_cnt   <= '0;
        end else if (issue) begin
            issue_cnt <= issue_cnt + 1'b1;
            gap_cnt   <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Capture the PRNG word accepted with each issue; it feeds the transform directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            prng_lat <= '0;
        end else if (issue) begin
            prng_lat <= prng_data;
        end
    end

endmodule

// File: rtl/polytomsg_masked_decode_sched.sv
// Sequencer for the masked Poly-to-message decode: streams share pairs
// into the transform and writes the returned share pairs, in order, to
// the result RAMs. Shares pass through untouched and never share a register.
module polytomsg_masked_decode_sched
    import kyber_pkg::*;
#(
    parameter int ISSUE_GAP = 2,
    parameter int FLUSH_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_SZ-1:0]  rd_addr,
    input  logic [COEFF_SZ-1:0] sh1_rdata,
    input  logic [COEFF_SZ-1:0] sh2_rdata,
    input  logic                prng_valid,
    output logic                prng_ready,
    input  logic [RAND_SZ-1:0]  prng_data,
    output logic                dp_ce,
    output logic [COEFF_SZ-1:0] dp_c1,
    output logic [COEFF_SZ-1:0] dp_c2,
    output logic [RAND_SZ-1:0]  dp_prng,
    input  logic                dp_valid,
    input  logic [COEFF_SZ-1:0] dp_y1,
    input  logic [COEFF_SZ-1:0] dp_y2,
    output logic                wr_en,
    output logic [ADDR_SZ-1:0]  wr_addr,
    output logic [COEFF_SZ-1:0] wr_y1,
    output logic [COEFF_SZ-1:0] wr_y2
);

    localparam int FW = $clog2(FLUSH_CYC) + 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
    localparam logic [ADDR_SZ:0] N_CNT = (ADDR_SZ+1)'(KYBER_N);

    sched_state_t     state, state_nx;
    logic [FW-1:0]    flush_cnt;
    logic [ADDR_SZ:0] ret_cnt;
    logic             start_acc;
    logic             run_en;
    logic             ret_active;
    logic             issue;
    logic             all_issued;

    assign start_acc  = (state == ST_IDLE) && start;
    assign run_en     = (state == ST_RUN);
    assign ret_active = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_DONE);
    assign busy       = (state == ST_RUN) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign rd_en      = issue;
    assign prng_ready = issue;

    polytomsg_sched_issue_ctr #(
        .ISSUE_GAP (ISSUE_GAP)
    ) u_issue (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .en         (run_en),
        .prng_valid (prng_valid),
        .prng_data  (prng_data),
        .issue      (issue),
        .addr       (rd_addr),
        .all_issued (all_issued),
        .prng_lat   (dp_prng)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_nx;
        end
    end

    // Post-reset flush timer; the transform pipeline has no reset of its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_FLUSH: if (flush_cnt == FLUSH_LAST) state_nx = ST_IDLE;
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (all_issued) state_nx = ST_DRAIN;
            ST_DRAIN: if (wr_en && (ret_cnt == N_CNT)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_FLUSH;
        endcase
    end

    // p1: transform strobe one cycle after the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_ce <= 1'b0;
        end else begin
            dp_ce <= issue;
        end
    end

    // Share-1 input register, loaded from RAM data in the strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_c1 <= '0;
        end else if (dp_ce) begin
            dp_c1 <= sh1_rdata;
        end
    end

    // Share-2 input register, kept separate from share 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_c2 <= '0;
        end else if (dp_ce) begin
            dp_c2 <= sh2_rdata;
        end
    end

    // Return side: register each transform result into the result RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_y1   <= '0;
            wr_y2   <= '0;
            ret_cnt <= '0;
        end else begin
            wr_en <= ret_active && dp_valid;
            if (start_acc) begin
                ret_cnt <= '0;
            end else if (ret_active && dp_valid) begin
                wr_addr <= ret_cnt[ADDR_SZ-1:0];
                wr_y1   <= dp_y1;
                wr_y2   <= dp_y2;
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_polytomsg_masked_decode_sched.sv
// Bench for the masked decode sequencer with a fixed-latency transform model.
module tb_polytomsg_masked_decode_sched;
    import kyber_pkg::*;

    localparam int GAP   = 2;
    localparam int FLUSH = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                busy, done, rd_en, prng_ready, dp_ce, wr_en;
    logic [ADDR_SZ-1:0]  rd_addr, wr_addr;
    logic [COEFF_SZ-1:0] sh1_rdata = '0, sh2_rdata = '0;
    logic                prng_valid = 1'b0;
    logic [RAND_SZ-1:0]  prng_data = '0;
    logic [COEFF_SZ-1:0] dp_c1, dp_c2, dp_y1, dp_y2, wr_y1, wr_y2;
    logic [RAND_SZ-1:0]  dp_prng;
    logic                dp_valid;

    always #5 clk = ~clk;

    polytomsg_masked_decode_sched #(.ISSUE_GAP(GAP), .FLUSH_CYC(FLUSH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .sh1_rdata(sh1_rdata), .sh2_rdata(sh2_rdata),
        .prng_valid(prng_valid), .prng_ready(prng_ready), .prng_data(prng_data),
        .dp_ce(dp_ce), .dp_c1(dp_c1), .dp_c2(dp_c2), .dp_prng(dp_prng),
        .dp_valid(dp_valid), .dp_y1(dp_y1), .dp_y2(dp_y2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_y1(wr_y1), .wr_y2(wr_y2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [RAND_SZ-1:0] obs, input logic [RAND_SZ-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode of an unmasked coefficient to one message bit.
    function automatic int dec(input logic [15:0] a, input logic [15:0] b);
        int x;
        x = (int'(a) + int'(b)) % KYBER_Q;
        return ((2 * x + KYBER_Q / 2) / KYBER_Q) % 2;
    endfunction

    // Share RAMs, 1-cycle read latency.
    logic [15:0] sh1_mem [KYBER_N];
    logic [15:0] sh2_mem [KYBER_N];
    always @(posedge clk) if (rd_en) begin
        sh1_rdata <= sh1_mem[rd_addr];
        sh2_rdata <= sh2_mem[rd_addr];
    end

    // PRNG source: word held until consumed; mode 1 offers a new word half the time.
    int prng_mode = 0;
    always @(posedge clk) if (!prng_valid || prng_ready) begin
        prng_valid <= (prng_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        prng_data  <= {16'($urandom), $urandom, $urandom};
    end

    // Transform model: samples inputs one cycle after ce, 6-stage valid shift, no reset.
    logic        samp = 1'b0;
    logic [5:0]  pv = '0;
    logic [12:0] p1 [6];
    logic [12:0] p2 [6];
    logic        stale_inj = 1'b0;
    always @(posedge clk) begin
        samp <= dp_ce;
        pv   <= {pv[4:0], samp};
        for (int i = 5; i > 0; i--) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
        p1[0] <= dp_prng[12:0];
        p2[0] <= 13'(dec(dp_c1, dp_c2)) - dp_prng[12:0];
    end
    assign dp_valid = pv[5] | stale_inj;
    assign dp_y1 = {3'b000, p1[5]};
    assign dp_y2 = {3'b000, p2[5]};

    logic rst_edge = 1'b1;
    always @(posedge clk) rst_edge <= rst;

    typedef struct packed { logic [15:0] c1; logic [15:0] c2; logic [RAND_SZ-1:0] w; } iss_t;
    typedef struct packed { int idx; int bitv; } res_t;
    iss_t iss_q [$];
    res_t res_q [$];
    int   n_wr = 0, n_rdy = 0, n_done = 0, cyc = 0, last_ce = 0, ce_in_run = 0, exp_rd = 0, res_idx = 0;
    bit   pend = 0, rdy_prev = 0;

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        iss_t e;
        res_t r;
        cyc++;
        if (rst_edge) begin
            iss_q.delete(); res_q.delete();
            pend = 0; ce_in_run = 0; exp_rd = 0; res_idx = 0; rdy_prev = 0;
        end else begin
            if (pend) begin
                pend = 0;
                if (iss_q.size() == 0) chk("ce_without_issue", 1, 0);
                else begin
                    e = iss_q.pop_front();
                    chk("dp_c1", dp_c1, e.c1);
                    chk("dp_c2", dp_c2, e.c2);
                    chk("dp_prng", dp_prng, e.w);
                    r.idx = res_idx; r.bitv = dec(e.c1, e.c2);
                    res_q.push_back(r);
                    res_idx++;
                end
            end
            if (dp_ce) begin
                chk("ce_after_ready", dp_ce, rdy_prev);
                if (prng_mode == 0 && ce_in_run > 0) chk("ce_spacing", cyc - last_ce, GAP);
                last_ce = cyc; ce_in_run++; pend = 1;
            end
            if (rd_en || prng_ready) begin
                chk("rd_en_eq_ready", rd_en, prng_ready);
                chk("rd_addr", rd_addr, exp_rd[7:0]);
                e.c1 = sh1_mem[rd_addr]; e.c2 = sh2_mem[rd_addr]; e.w = prng_data;
                iss_q.push_back(e);
                exp_rd++; n_rdy++;
            end
            rdy_prev = prng_ready;
            if (wr_en) begin
                n_wr++;
                if (res_q.size() == 0) chk("unexpected_write", wr_en, 0);
                else begin
                    r = res_q.pop_front();
                    chk("wr_addr", wr_addr, r.idx[7:0]);
                    chk("wr_sum13", 13'(wr_y1 + wr_y2), 13'(r.bitv));
                end
            end
            if (done) begin
                n_done++; ce_in_run = 0; exp_rd = 0; res_idx = 0;
            end
        end
    end

    task automatic wait_done(input bit poke, input int b_wr, input int b_rdy, input int b_done);
        int k = 0;
        while (done !== 1'b1 && k < 4000) begin @(negedge clk); k++; end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("write_count", n_wr - b_wr, KYBER_N);
        chk("ready_count", n_rdy - b_rdy, KYBER_N);
        chk("done_count", n_done - b_done, 1);
    endtask

    initial begin
        int k, bw, br, bd;
        for (int i = 0; i < KYBER_N; i++) begin
            sh1_mem[i] = 16'(i);
            sh2_mem[i] = 16'(16'h100 + i);
        end
        for (int i = 0; i < 6; i++) begin p1[i] = '0; p2[i] = '0; end

        // Reset values, with start already held high.
        rst = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0); chk("rst_prng_ready", prng_ready, 0);
        chk("rst_dp_ce", dp_ce, 0); chk("rst_wr_en", wr_en, 0);
        chk("rst_dp_c1", dp_c1, 0); chk("rst_dp_c2", dp_c2, 0);
        chk("rst_dp_prng", dp_prng, 0); chk("rst_wr_addr", wr_addr, 0);

        // Flush: start ignored, stale valids discarded.
        bw = n_wr; br = n_rdy; bd = n_done;
        rst = 1'b0; stale_inj = 1'b1;
        for (int i = 0; i < FLUSH; i++) begin
            @(negedge clk);
            chk("flush_busy", busy, 0);
            chk("flush_wr_en", wr_en, 0);
        end
        stale_inj = 1'b0;
        k = 0;
        while (busy !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("start_accept_delay", k, 1);
        start = 1'b0;
        wait_done(1'b0, bw, br, bd);

        // Random shares, 50% PRNG availability, start pokes in RUN and in DONE.
        for (int i = 0; i < KYBER_N; i++) begin
            sh1_mem[i] = 16'($urandom_range(0, KYBER_Q - 1));
            sh2_mem[i] = 16'($urandom_range(0, KYBER_Q - 1));
        end
        prng_mode = 1;
        bw = n_wr; br = n_rdy; bd = n_done;
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        repeat (50) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(1'b1, bw, br, bd);
        repeat (10) @(negedge clk);
        chk("done_start_ignored", busy, 0);
        chk("one_done_per_start", n_done - bd, 1);

        // Reset in the middle of a run, once ret_cnt has reached 100.
        prng_mode = 0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        k = 0;
        while (!(wr_en === 1'b1 && wr_addr === 8'd99) && k < 2000) begin @(negedge clk); k++; end
        chk("reached_addr99", wr_addr, 99);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rd_en", rd_en, 0);   chk("abort_prng_ready", prng_ready, 0);
        chk("abort_dp_ce", dp_ce, 0);   chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);     chk("abort_done", done, 0);
        rst = 1'b0;
        bw = n_wr;
        repeat (20) @(negedge clk);
        chk("no_writes_after_abort", n_wr - bw, 0);
        chk("idle_after_abort", busy, 0);

        // Full run after the abort, addresses from 0.
        bw = n_wr; br = n_rdy; bd = n_done;
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done(1'b0, bw, br, bd);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
